// File: rtl/regfile_writeback_queue.sv
// Write-back queue for the register file: buffers ALU and load results in an
// in-order FIFO, drains one write per cycle, and exposes scoreboard/forwarding.
module regfile_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int DW    = 16,
  parameter int AW    = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         alu_valid,
  output logic                         alu_ready,
  input  logic [AW-1:0]                alu_rd,
  input  logic [DW-1:0]                alu_data,
  input  logic                         mem_valid,
  output logic                         mem_ready,
  input  logic [AW-1:0]                mem_rd,
  input  logic [DW-1:0]                mem_data,
  input  logic                         wb_stall,
  output logic                         rf_write_en,
  output logic [AW-1:0]                rf_rd,
  output logic [DW-1:0]                rf_data,
  input  logic [AW-1:0]                q1_reg,
  input  logic [AW-1:0]                q2_reg,
  output logic                         q1_hit,
  output logic                         q2_hit,
  output logic [DW-1:0]                q1_data,
  output logic [DW-1:0]                q2_data,
  output logic [(1<<AW)-1:0]           pending,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int NR = 1 << AW;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0] rd_q   [DEPTH];
  logic [AW-1:0] rd_d   [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          not_full_s;
  logic          push_s;
  logic [AW-1:0] push_rd_s;
  logic [DW-1:0] push_data_s;

  assign count = count_q;

  // Handshake readies (from registered count only), push selection and head drain.
  always_comb begin
    not_full_s  = (count_q != FULL);
    mem_ready   = !reset && not_full_s;
    alu_ready   = !reset && not_full_s && !mem_valid;
    push_s      = (mem_valid && mem_ready) || (alu_valid && alu_ready);
    if (mem_valid) begin
      push_rd_s   = mem_rd;
      push_data_s = mem_data;
    end else begin
      push_rd_s   = alu_rd;
      push_data_s = alu_data;
    end
    rf_write_en = (count_q != {CW{1'b0}}) && !wb_stall && !reset;
    if (count_q != {CW{1'b0}}) begin
      rf_rd   = rd_q[head_q];
      rf_data = data_q[head_q];
    end else begin
      rf_rd   = {AW{1'b0}};
      rf_data = {DW{1'b0}};
    end
  end

  // Next-state for entry array, pointers and occupancy.
  always_comb begin
    rd_d    = rd_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (reset) begin
      head_d  = {PW{1'b0}};
      tail_d  = {PW{1'b0}};
      count_d = {CW{1'b0}};
    end else begin
      if (push_s) begin
        rd_d[tail_q]   = push_rd_s;
        data_d[tail_q] = push_data_s;
        tail_d         = tail_q + PW'(1);
      end else begin
        tail_d = tail_q;
      end
      if (rf_write_en) begin
        head_d = head_q + PW'(1);
      end else begin
        head_d = head_q;
      end
      case ({push_s, rf_write_en})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; reset is folded into the next-state logic.
  always_ff @(posedge clk) begin
    rd_q    <= rd_d;
    data_q  <= data_d;
    head_q  <= head_d;
    tail_q  <= tail_d;
    count_q <= count_d;
  end

  // Scoreboard and forwarding: walk oldest to youngest so the youngest match wins.
  always_comb begin
    logic [PW-1:0] idx;
    logic          vld;
    logic          m1;
    logic          m2;
    pending = {NR{1'b0}};
    q1_hit  = 1'b0;
    q2_hit  = 1'b0;
    q1_data = {DW{1'b0}};
    q2_data = {DW{1'b0}};
    idx     = {PW{1'b0}};
    vld     = 1'b0;
    m1      = 1'b0;
    m2      = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      idx     = head_q + PW'(i);
      vld     = (CW'(i) < count_q);
      m1      = vld && (rd_q[idx] == q1_reg);
      m2      = vld && (rd_q[idx] == q2_reg);
      pending = pending | (vld ? (NR'(1) << rd_q[idx]) : {NR{1'b0}});
      q1_hit  = q1_hit | m1;
      q2_hit  = q2_hit | m2;
      q1_data = m1 ? data_q[idx] : q1_data;
      q2_data = m2 ? data_q[idx] : q2_data;
    end
  end

endmodule

// File: doc/regfile_writeback_queue.md
# regfile_writeback_queue

Writer-side front end for the 8×16-bit register file. It accepts completed results from the ALU and the load path over valid/ready handshakes and buffers them in a 4-entry in-order FIFO. It then drives the register file's single write port (rd / write enable / data) at one write per cycle. It also publishes a pending-write scoreboard and two forwarding lookups so decode can read values still in flight.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- DW, 16, data width.
- AW, 3, register address width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- alu_valid  in  1  ALU result offered.
- alu_ready  out  1  ALU result accepted when valid&ready at clk edge.
- alu_rd  in  AW  ALU destination register.
- alu_data  in  DW  ALU result.
- mem_valid  in  1  load result offered.
- mem_ready  out  1  load result accepted when valid&ready at clk edge.
- mem_rd  in  AW  load destination register.
- mem_data  in  DW  load result.
- wb_stall  in  1  register-file write port unavailable this cycle.
- rf_write_en  out  1  write strobe to register file.
- rf_rd  out  AW  write address.
- rf_data  out  DW  write data.
- q1_reg, q2_reg  in  AW  forwarding lookup addresses (rs1, rs2).
- q1_hit, q2_hit  out  1  a queued entry targets the looked-up register.
- q1_data, q2_data  out  DW  data of the youngest matching entry.
- pending  out  8  bit r set when any queued entry targets register r.
- count  out  3  number of valid FIFO entries, 0..DEPTH.

## Operation
- State: entry array (rd, data), head pointer, tail pointer, count register. Pointers wrap modulo DEPTH.
- Acceptance is one push per cycle, with fixed priority to loads.
  - mem_ready = (count != DEPTH).
  - alu_ready = (count != DEPTH) && !mem_valid.
  - Readies use the registered count only. A pop in the same cycle does not free a slot for a push; ready is conservative.
- Push: on a clk edge with an accepted handshake, write {rd, data} at tail and advance tail.
- Drain is combinational from the head entry:
  - rf_write_en = (count != 0) && !wb_stall && !reset.
  - rf_rd and rf_data equal the head entry when count != 0, else 0.
  - Pop: on a clk edge with rf_write_en = 1, advance head.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Push only: count+1. Pop only: count−1. count never exceeds DEPTH and never underflows.
- Writes occur strictly in acceptance order. Two queued writes to the same register are both performed, oldest first.
- pending[r] is the OR over valid entries of (entry.rd == r). It is combinational from registered state.
- Forwarding:
  - qN_hit = 1 if any valid entry has rd == qN_reg.
  - qN_data is taken from the youngest such entry, i.e. nearest the tail.
  - When there is no hit, qN_data = 0.
  - Lookups do not see the entry being pushed in the same cycle.
- Reset (synchronous, any cycle, including mid-drain):
  - At the edge, head, tail and count go to 0 and all queued entries are discarded.
  - While reset is high: rf_write_en = 0, both readies = 0, no pop, no push.

## Timing
- Reset values: rf_write_en 0, rf_rd 0, rf_data 0, count 0, pending 0, q1_hit/q2_hit 0, q1_data/q2_data 0, alu_ready/mem_ready 0 during reset and 1 the first cycle after.
- Latency: a result accepted at edge N appears on rf_write_en/rf_rd/rf_data in cycle N+1 (after edge N) if the FIFO was empty and wb_stall = 0. The register file captures it during that cycle, and the entry pops at edge N+1.
- Throughput: one write per cycle sustained when wb_stall = 0.
- While wb_stall = 1: the head is held, rf_write_en = 0, and pushes continue until count = DEPTH.
- Full: with count = DEPTH, both readies = 0 even if a pop occurs that cycle.
- Empty: with count = 0, rf_write_en = 0 regardless of wb_stall.
- The push valid/rd/data must be held stable by the source until accepted. The block samples them only at an accepting edge.

## Test plan
- Single ALU result: after reset, alu_valid with rd=3, data=16'h1234. Required: alu_ready=1 and accepted at edge 0. Cycle 1 shows rf_write_en=1, rf_rd=3, rf_data=16'h1234, pending=8'b0000_1000. Cycle 2 shows count=0 and pending=0.
- Priority: mem_valid (rd=1, 16'hAAAA) and alu_valid (rd=2, 16'h5555) in the same cycle. Required: mem accepted first with alu_ready=0. ALU accepted the next cycle. Writes occur in order r1, then r2 on consecutive cycles.
- Full/stall: hold wb_stall=1 and push 5 results (rd 0..4, data 16'h0010..16'h0014). Required: count reaches 4 and readies drop to 0, so the fifth result is not accepted. Release the stall: writes for rd 0..3, then the fifth result is accepted and written.
- Forwarding, same register: with wb_stall=1, push rd=5 data 16'h0001, then rd=5 data 16'h0002. Set q1_reg=5. Required: q1_hit=1 and q1_data=16'h0002. With q2_reg=6: q2_hit=0 and q2_data=0. On drain, r5 is written 16'h0001 then 16'h0002.
- Reset mid-operation: with 3 entries queued and draining, assert reset for one cycle. Required: rf_write_en=0 in that cycle. After the edge: count=0, pending=0, no further writes, readies=1.
- Wrap-around: 12 back-to-back accepted pushes with no stall. Required: each written exactly once, in order, with correct rd/data, and count never exceeds 1.
